// File: rtl/key_onehot_latch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : key_onehot_latch
// Brief    : Sync + debounce four buttons, queue presses, issue one-hot
//            requests under a valid/ack handshake.
// Revision : 1.0
// ============================================================================
module key_onehot_latch #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    input  logic       ack,
    output logic       i0,
    output logic       i1,
    output logic       i2,
    output logic       i3,
    output logic       valid
);

    localparam logic [7:0] c_cnt_last = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_hold  = 1'b1;

    logic [3:0] r_s1;
    logic [3:0] r_s2;
    logic [3:0] r_pending;
    logic [3:0] r_out;
    logic       r_valid;
    logic [0:0] r_state;

    logic [3:0] w_deb;
    logic [3:0] w_rise;
    logic [3:0] w_pick;
    logic [3:0] w_clear;
    logic [3:0] w_out_nxt;
    logic       w_valid_nxt;
    logic [0:0] w_state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 4'b0000;
            r_s2 <= 4'b0000;
        end else begin
            r_s1 <= key;
            r_s2 <= r_s1;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_debounce
        logic [7:0] r_cnt;
        logic       r_deb;
        logic       w_settle;

        assign w_settle  = (r_s2[g] != r_deb) && (r_cnt == c_cnt_last);
        // A press is the settle edge on which the new level is high.
        assign w_rise[g] = w_settle && r_s2[g];
        assign w_deb[g]  = r_deb;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= 8'd0;
                r_deb <= 1'b0;
            end else if (r_s2[g] == r_deb) begin
                r_cnt <= 8'd0;
            end else if (w_settle) begin
                r_deb <= r_s2[g];
                r_cnt <= 8'd0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_pick = 4'b0000;
        if (r_pending[3])      w_pick = 4'b1000;
        else if (r_pending[2]) w_pick = 4'b0100;
        else if (r_pending[1]) w_pick = 4'b0010;
        else if (r_pending[0]) w_pick = 4'b0001;
    end

    // Set has priority over the grant clear, so a fresh press is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 4'b0000;
        end else begin
            r_pending <= (r_pending & ~w_clear) | w_rise;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_out   <= 4'b0000;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_valid_nxt = r_valid;
        w_clear     = 4'b0000;
        case (r_state)
            c_st_idle: begin
                if (|r_pending) begin
                    w_clear     = w_pick;
                    w_out_nxt   = w_pick;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = c_st_hold;
                end else begin
                    w_out_nxt   = 4'b0000;
                    w_valid_nxt = 1'b0;
                end
            end
            c_st_hold: begin
                if (ack) begin
                    w_out_nxt   = 4'b0000;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_out_nxt   = 4'b0000;
                w_valid_nxt = 1'b0;
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    assign i0    = r_out[0];
    assign i1    = r_out[1];
    assign i2    = r_out[2];
    assign i3    = r_out[3];
    assign valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_key_onehot_latch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_key_onehot_latch
// Brief    : Directed and randomized self-checking bench for key_onehot_latch.
// Revision : 1.0
// ============================================================================
module tb_key_onehot_latch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'b0000;
    logic       ack = 1'b0;
    logic       i0, i1, i2, i3, valid;
    logic [4:0] w_obs;

    int n_total = 0;
    int n_bad   = 0;

    key_onehot_latch #(.DEBOUNCE_CYCLES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .key   (key),
        .ack   (ack),
        .i0    (i0),
        .i1    (i1),
        .i2    (i2),
        .i3    (i3),
        .valid (valid)
    );

    always #5 clk = ~clk;

    assign w_obs = {valid, i3, i2, i1, i0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_valid(input string tag, input int maxc);
        int k = 0;
        while (!valid && k < maxc) begin
            tick();
            k++;
        end
        check({tag, "_timeout"}, 32'(valid), 32'd1);
    endtask

    task automatic expect_quiet(input string tag, input int n);
        logic seen = 1'b0;
        repeat (n) begin
            tick();
            if (w_obs != 5'b00000) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    // Continuous invariants and grant counting
    logic [4:0] prev_obs   = 5'b00000;
    logic       prev_hold  = 1'b0;
    logic       prev_valid = 1'b0;
    logic       stress_en  = 1'b0;
    int         grants [4] = '{0, 0, 0, 0};

    always @(negedge clk) begin
        check("onehot", 32'($countones({i3, i2, i1, i0}) <= 1), 32'd1);
        check("valid_or", 32'(valid), 32'(i0 | i1 | i2 | i3));
        if (prev_hold) check("hold_stable", 32'(w_obs), 32'(prev_obs));
        if (stress_en && valid && !prev_valid) begin
            for (int b = 0; b < 4; b++) if (w_obs[b]) grants[b]++;
        end
        prev_obs   = w_obs;
        prev_hold  = valid && !ack && !rst;
        prev_valid = valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [4:0] tr [20];
    logic [4:0] exp_tr;
    logic [3:0] lvl;
    logic [3:0] nlvl;
    logic [3:0] gl;
    int         rises [4];
    int         hold_cnt;

    initial begin
        // Reset
        rst = 1'b1;
        ticks(3);
        check("rst_out", 32'(w_obs), 32'd0);

        // Single press on key[2], set before edge 0
        rst = 1'b0;
        key = 4'b0100;
        ticks(6);
        check("press_e5", 32'(w_obs), 32'd0);
        tick();
        check("press_e6", 32'(w_obs), 32'b10100);
        ticks(3);
        check("hold_e9", 32'(w_obs), 32'b10100);
        ack = 1'b1;
        tick();
        check("ack_e10", 32'(w_obs), 32'd0);
        ack = 1'b0;
        expect_quiet("single_no_repeat", 20);
        key = 4'b0000;
        expect_quiet("release_quiet", 20);

        // Glitch of 3 cycles on key[1]
        key[1] = 1'b1;
        ticks(3);
        key[1] = 1'b0;
        expect_quiet("glitch", 30);

        // Simultaneous press with ack tied high
        key = 4'b1010;
        ack = 1'b1;
        for (int j = 0; j < 20; j++) begin
            tick();
            tr[j] = w_obs;
        end
        for (int j = 0; j < 20; j++) begin
            exp_tr = (j == 6) ? 5'b11000 : (j == 8) ? 5'b10010 : 5'b00000;
            check($sformatf("simul_e%0d", j), 32'(tr[j]), 32'(exp_tr));
        end
        key = 4'b0000;
        ack = 1'b0;
        ticks(20);

        // Press during HOLD
        key = 4'b0001;
        wait_valid("hold_grant", 20);
        check("hold_i0", 32'(w_obs), 32'b10001);
        repeat (2) begin
            key[2] = 1'b1;
            ticks(8);
            key[2] = 1'b0;
            ticks(8);
        end
        check("hold_i0_stable", 32'(w_obs), 32'b10001);
        ack = 1'b1;
        tick();
        check("hold_ack", 32'(w_obs), 32'd0);
        ack = 1'b0;
        tick();
        check("queued_i2", 32'(w_obs), 32'b10100);
        ticks(5);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("queued_ack", 32'(w_obs), 32'd0);
        key = 4'b0000;
        expect_quiet("absorbed", 30);

        // Reset mid-HOLD with key[1] pending
        key = 4'b1010;
        wait_valid("rst_grant", 20);
        check("rst_i3", 32'(w_obs), 32'b11000);
        key = 4'b0000;
        ticks(10);
        check("rst_i3_held", 32'(w_obs), 32'b11000);
        rst = 1'b1;
        tick();
        check("rst_mid", 32'(w_obs), 32'd0);
        rst = 1'b0;
        expect_quiet("rst_discard", 40);

        // Key held through reset gives one fresh press
        key = 4'b0100;
        wait_valid("held_grant", 20);
        check("held_i2", 32'(w_obs), 32'b10100);
        rst = 1'b1;
        tick();
        check("held_rst", 32'(w_obs), 32'd0);
        rst = 1'b0;
        wait_valid("held_regrant", 20);
        check("held_i2_again", 32'(w_obs), 32'b10100);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        key = 4'b0000;
        expect_quiet("held_once", 30);

        // Random stress: levels held 30 cycles, occasional 2-cycle glitches
        stress_en = 1'b1;
        lvl = 4'b0000;
        hold_cnt = 0;
        for (int b = 0; b < 4; b++) rises[b] = 0;
        for (int seg = 0; seg < 330; seg++) begin
            nlvl = 4'($urandom_range(0, 15));
            for (int b = 0; b < 4; b++) if (nlvl[b] && !lvl[b]) rises[b]++;
            lvl = nlvl;
            gl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            for (int c = 0; c < 30; c++) begin
                key = (c == 12 || c == 13) ? (lvl ^ gl) : lvl;
                tick();
                if (valid) hold_cnt++;
                else       hold_cnt = 0;
                ack = (hold_cnt >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            end
        end
        key = 4'b0000;
        repeat (100) begin
            tick();
            if (valid) hold_cnt++;
            else       hold_cnt = 0;
            ack = (hold_cnt >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        ack = 1'b0;
        tick();
        stress_en = 1'b0;
        for (int b = 0; b < 4; b++)
            check($sformatf("stress_grants_k%0d", b), 32'(grants[b]), 32'(rises[b]));
        check("stress_idle", 32'(w_obs), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_onehot_latch.md
# key_onehot_latch

Front-end stage for the 4-to-2 encoder. It takes four raw push-button lines, synchronises and debounces each one, and turns every debounced press into a single one-hot request on `i0`..`i3`. Each request is held stable under a valid/ack handshake, so the downstream encoder always sees at most one active line. Presses that arrive while a request is outstanding are queued per key and served in fixed priority order.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a debounced bit changes; legal range 1..255.
- `clk` input 1: single system clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `key` input 4: raw, asynchronous button levels; bit n corresponds to `in`.
- `ack` input 1: consumer accepts the current request; sampled only while `valid`=1.
- `i0`, `i1`, `i2`, `i3` output 1 each: registered one-hot request lines, all 0 when idle.
- `valid` output 1: high while a request is presented.

## Operation
- Synchroniser: a two-flop chain per bit, `key` → `s1` → `s2`.
- Debounce, per bit, with counter `cnt` (8 bits) and debounced level `deb`:
  - If `s2`==`deb`: `cnt`←0.
  - Else if `cnt`==`DEBOUNCE_CYCLES`-1: `deb`←`s2`, `cnt`←0.
  - Else: `cnt`←`cnt`+1.
- Press event: on the edge where `deb` goes 0→1, the bit's `pending` flag is set. Releases (1→0) generate nothing.
- `pending` is sticky. A second press of a key that is already pending is absorbed, not counted.
- FSM with two states, IDLE and HOLD:
  - IDLE, `pending`==0: outputs 0, stay in IDLE.
  - IDLE, `pending`!=0: grant the highest-index pending bit (priority 3>2>1>0). Drive its one-hot line, set `valid`=1, clear that `pending` bit, go to HOLD.
  - HOLD, `ack`=0: outputs and `valid` held unchanged.
  - HOLD, `ack`=1: `valid`←0, `i0`..`i3`←0, go to IDLE.
- Pending updates and grant clears in the same cycle are both applied. A new press on the bit being cleared wins, so it stays set.
- `ack` while in IDLE is ignored.
- Invariant: `i0`..`i3` are all-zero or exactly one-hot. `valid` equals the OR of `i0`..`i3`.

## Timing
- Reset values: `i0`..`i3`=0, `valid`=0, state IDLE. Also `s1`, `s2`, `deb`, `cnt` and `pending` all 0.
- Reset mid-HOLD: outputs drop to 0 at the reset edge, and the queued presses are discarded.
- A key held high through reset is re-debounced after reset and produces one press event.
- Latency, for `key` rising before edge E and held:
  - `s2`=1 after edge E+1.
  - `deb` and `pending` set after edge E+1+`DEBOUNCE_CYCLES`.
  - `valid` and the one-hot line high after edge E+2+`DEBOUNCE_CYCLES` (from IDLE).
- Glitch filtering: an `s2` deviation shorter than `DEBOUNCE_CYCLES` cycles leaves `deb` unchanged and `cnt` returns to 0.
- Handshake: the transfer completes on the edge where `valid`=1 and `ack`=1. Outputs are 0 for at least one cycle before the next grant.
- Maximum throughput is one request per two cycles. With `ack` tied high, `valid` alternates 1,0,1,0 while `pending`!=0.
- Simultaneous debounced presses on several keys are all captured in the same cycle and granted highest index first.

## Test plan
- Single press, `DEBOUNCE_CYCLES`=4: `key`=4'b0100 set before edge 0 and held.
  - Required: `valid`=1 and `i2`=1 after edge 6, others 0.
  - `ack`=1 for one cycle, sampled at edge 10: all outputs 0 after edge 10, no further request.
- Glitch: `key[1]` high for 3 cycles, then low. Required: `valid` stays 0 forever, `pending`=0.
- Simultaneous press: `key`=4'b1010 together, `ack` tied high.
  - Required: `i3` pulse first, then a 0 cycle, then an `i1` pulse, then idle.
- Press during HOLD: `key[0]` granted and `ack` held 0; during HOLD, press and release `key[2]` twice.
  - Required: `i0` held stable until `ack`.
  - After `ack`, exactly one `i2` request follows (sticky pending, second press absorbed).
- Reset mid-operation: assert `rst` for one edge while `i3`=1 in HOLD with `key[1]` pending.
  - Required: all outputs 0 after that edge, and no `i1` request afterwards unless `key[1]` is pressed again or held.
- Random stress: random key activity and random `ack` over 10k cycles.
  - Check: one-hot invariant, `valid` == OR(`i0`..`i3`), and no output change in HOLD while `ack`=0.
  - Check: the count of grants per key equals the count of debounced press events not absorbed by sticky `pending`.
